// File: rtl/instrumented_adder_pkg.sv
// rtl/instrumented_adder_pkg.sv - shared state encoding and default sizes for the adder measurement controller
package instrumented_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } meas_state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_NCH         = 2;
  localparam int DEF_CNT_WIDTH   = 24;
  localparam int DEF_SETTLE      = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Channel-select width, never narrower than one bit.
  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// rtl/ring_edge_sync.sv - multi-flop synchroniser for one asynchronous ring output plus rising-edge pulse
module ring_edge_sync
  import instrumented_adder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ring_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/instrumented_adder_ctrl.sv
// rtl/instrumented_adder_ctrl.sv - selects an adder channel, closes its ring loop and counts ring edges over a window
module instrumented_adder_ctrl
  import instrumented_adder_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NCH         = DEF_NCH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SETTLE      = DEF_SETTLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      start,
  input  logic                      abort,
  input  logic [sel_width(NCH)-1:0] chan_sel,
  input  logic [WIDTH-1:0]          a_in,
  input  logic [WIDTH-1:0]          b_in,
  input  logic [CNT_WIDTH-1:0]      window_len,
  input  logic [NCH-1:0]            ring_in,
  input  logic [WIDTH-1:0]          s_in,
  output logic [WIDTH-1:0]          a_out,
  output logic [WIDTH-1:0]          b_out,
  output logic [NCH-1:0]            ring_en,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      count,
  output logic [WIDTH-1:0]          sum_out,
  output logic                      overflow
);

  localparam int                   CW      = sel_width(NCH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  meas_state_e          state_q;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic [NCH-1:0]       ring_en_q, onehot_d, rise;
  logic [CNT_WIDTH-1:0] win_len_q, timer_q, work_q, work_d, count_q;
  logic                 ovf_work_q, ovf_work_d, overflow_q, done_q;
  logic                 sel_rise;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    ring_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .ring_i (ring_in[i]),
      .rise_o (rise[i])
    );
  end

  // The enabled ring is the measured one, so an out-of-range channel never counts.
  assign sel_rise = |(rise & ring_en_q);

  always_comb begin
    onehot_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_sel == CW'(i)) onehot_d[i] = 1'b1;
    end
  end

  // Saturating counter; reaching all-ones already flags the result as unreliable.
  always_comb begin
    work_d     = work_q;
    ovf_work_d = ovf_work_q;
    if (sel_rise) begin
      if (work_q != CNT_MAX) work_d = work_q + CNT_ONE;
      if (work_d == CNT_MAX) ovf_work_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      ring_en_q  <= '0;
      win_len_q  <= '0;
      timer_q    <= '0;
      work_q     <= '0;
      count_q    <= '0;
      ovf_work_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q   <= ST_IDLE;
        ring_en_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              a_q        <= a_in;
              b_q        <= b_in;
              win_len_q  <= window_len;
              ring_en_q  <= onehot_d;
              timer_q    <= CNT_WIDTH'(SETTLE - 1);
              work_q     <= '0;
              ovf_work_q <= 1'b0;
              state_q    <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (timer_q != '0) begin
              timer_q <= timer_q - CNT_ONE;
            end else if (win_len_q == '0) begin
              count_q    <= work_q;
              overflow_q <= ovf_work_q;
              sum_q      <= s_in;
              done_q     <= 1'b1;
              ring_en_q  <= '0;
              state_q    <= ST_DONE;
            end else begin
              timer_q <= win_len_q - CNT_ONE;
              state_q <= ST_COUNT;
            end
          end
          ST_COUNT: begin
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            if (timer_q != '0) begin
              timer_q <= timer_q - CNT_ONE;
            end else begin
              count_q    <= work_d;
              overflow_q <= ovf_work_d;
              sum_q      <= s_in;
              done_q     <= 1'b1;
              ring_en_q  <= '0;
              state_q    <= ST_DONE;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign ring_en  = ring_en_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign count    = count_q;
  assign sum_out  = sum_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_instrumented_adder_ctrl.sv
// tb/tb_instrumented_adder_ctrl.sv - table-driven and sequence checks for instrumented_adder_ctrl
module tb_instrumented_adder_ctrl;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, abort;
  logic [1:0]  chan_sel;
  logic [31:0] a_in, b_in, s_in, a_out, b_out, sum_out;
  logic [23:0] window_len, count;
  logic [2:0]  ring_in, ring_en;
  logic        busy, done, overflow;

  logic        start4, abort4;
  logic [0:0]  chan4, ring4, ring_en4;
  logic [7:0]  a4, b4, s4, a_out4, b_out4, sum4;
  logic [3:0]  win4, count4;
  logic        busy4, done4, overflow4;

  assign s_in = a_out + b_out;
  assign s4   = a_out4 + b_out4;

  instrumented_adder_ctrl #(.WIDTH(32), .NCH(3), .CNT_WIDTH(24), .SETTLE(S), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort), .chan_sel(chan_sel),
    .a_in(a_in), .b_in(b_in), .window_len(window_len), .ring_in(ring_in), .s_in(s_in),
    .a_out(a_out), .b_out(b_out), .ring_en(ring_en), .busy(busy), .done(done),
    .count(count), .sum_out(sum_out), .overflow(overflow)
  );

  instrumented_adder_ctrl #(.WIDTH(8), .NCH(1), .CNT_WIDTH(4), .SETTLE(S), .SYNC_STAGES(2)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start4), .abort(abort4), .chan_sel(chan4),
    .a_in(a4), .b_in(b4), .window_len(win4), .ring_in(ring4), .s_in(s4),
    .a_out(a_out4), .b_out(b_out4), .ring_en(ring_en4), .busy(busy4), .done(done4),
    .count(count4), .sum_out(sum4), .overflow(overflow4)
  );

  typedef struct {
    logic [1:0]  chan;
    logic [31:0] a;
    logic [31:0] b;
    logic [23:0] win;
    int          half;
    bit          inv;
    int          exp_cnt;
    logic [31:0] exp_sum;
    logic [2:0]  exp_en;
  } vec_t;

  vec_t vecs[6];

  int   n_pass = 0;
  int   n_total = 0;
  int   ph = 0;
  int   half = 0;
  bit   inv = 1'b0;
  logic ring_bit = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Ring waveform: level (ph/half) mod 2, optionally inverted, ph counted from the start negedge.
  task automatic set_ring();
    if (half > 0) ring_bit = ((((ph / half) % 2) != 0) ? 1'b1 : 1'b0) ^ inv;
    else ring_bit = 1'b0;
    ring_in = {3{ring_bit}};
    ring4   = ring_bit;
  endtask

  task automatic tick();
    @(negedge clk);
    ph++;
    set_ring();
  endtask

  task automatic run_main(input vec_t v, input string tag);
    int lat;
    int early;
    lat   = 1 + S + int'(v.win);
    early = 0;
    chan_sel = v.chan; a_in = v.a; b_in = v.b; window_len = v.win;
    half = v.half; inv = v.inv; ph = 0; set_ring();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " ring_en"}, 64'(ring_en), 64'(v.exp_en));
    chk({tag, " busy"}, 64'(busy), 64'd1);
    chk({tag, " a_out"}, 64'(a_out), 64'(v.a));
    for (int c = 1; c < lat; c++) begin
      if (done) early++;
      tick();
    end
    chk({tag, " early done"}, 64'(early), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " count"}, 64'(count), 64'(v.exp_cnt));
    chk({tag, " sum"}, 64'(sum_out), 64'(v.exp_sum));
    chk({tag, " overflow"}, 64'(overflow), 64'd0);
    tick();
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    chk({tag, " ring_en after"}, 64'(ring_en), 64'd0);
  endtask

  task automatic run4(input logic [3:0] win, input int h, input bit iv, input logic [7:0] a,
                      input logic [7:0] b, input int exp_cnt, input logic exp_ovf,
                      input logic [7:0] exp_sum, input string tag);
    int lat;
    lat = 1 + S + int'(win);
    chan4 = 1'b0; a4 = a; b4 = b; win4 = win;
    half = h; inv = iv; ph = 0; set_ring();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c < lat; c++) tick();
    chk({tag, " done"}, 64'(done4), 64'd1);
    chk({tag, " count"}, 64'(count4), 64'(exp_cnt));
    chk({tag, " overflow"}, 64'(overflow4), 64'(exp_ovf));
    chk({tag, " sum"}, 64'(sum4), 64'(exp_sum));
    tick();
  endtask

  initial begin
    int ndone;
    int first;
    vec_t pr;

    rst = 1'b1; start = 1'b0; abort = 1'b0; chan_sel = '0; a_in = '0; b_in = '0; window_len = '0;
    start4 = 1'b0; abort4 = 1'b0; chan4 = '0; a4 = '0; b4 = '0; win4 = '0;
    set_ring();

    vecs[0] = '{chan: 2'd0, a: 32'd5, b: 32'd7, win: 24'd10, half: 2, inv: 1'b0,
                exp_cnt: 2, exp_sum: 32'd12, exp_en: 3'b001};
    vecs[1] = '{chan: 2'd1, a: 32'hFFFF_FFFF, b: 32'd1, win: 24'd20, half: 3, inv: 1'b0,
                exp_cnt: 4, exp_sum: 32'd0, exp_en: 3'b010};
    vecs[2] = '{chan: 2'd2, a: 32'd100, b: 32'd200, win: 24'd7, half: 1, inv: 1'b0,
                exp_cnt: 4, exp_sum: 32'd300, exp_en: 3'b100};
    vecs[3] = '{chan: 2'd3, a: 32'd1, b: 32'd2, win: 24'd12, half: 1, inv: 1'b0,
                exp_cnt: 0, exp_sum: 32'd3, exp_en: 3'b000};
    vecs[4] = '{chan: 2'd0, a: 32'd9, b: 32'd9, win: 24'd0, half: 1, inv: 1'b0,
                exp_cnt: 0, exp_sum: 32'd18, exp_en: 3'b001};
    vecs[5] = '{chan: 2'd1, a: 32'h1234, b: 32'h10, win: 24'd1, half: 1, inv: 1'b0,
                exp_cnt: 1, exp_sum: 32'h1244, exp_en: 3'b010};

    repeat (3) @(negedge clk);
    chk("reset ring_en", 64'(ring_en), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset count", 64'(count), 64'd0);
    chk("reset sum", 64'(sum_out), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset a_out", 64'(a_out), 64'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_main(vecs[i], $sformatf("vec%0d", i));

    // Abort during COUNT keeps the previous result.
    chan_sel = 2'd0; a_in = 32'd11; b_in = 32'd22; window_len = 24'd20;
    half = 1; inv = 1'b0; ph = 0; set_ring();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("abort pre busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort ring_en", 64'(ring_en), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort count held", 64'(count), 64'd1);
    chk("abort sum held", 64'(sum_out), 64'h1244);
    ndone = 0;
    repeat (25) begin
      tick();
      if (done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);

    start = 1'b1; abort = 1'b1;
    tick();
    chk("start+abort idle", 64'(busy), 64'd0);
    start = 1'b0; abort = 1'b0;
    tick();

    // Start held high across DONE: second start only accepted the cycle after.
    chan_sel = 2'd1; a_in = 32'd3; b_in = 32'd4; window_len = 24'd3;
    half = 1; inv = 1'b0; ph = 0; set_ring();
    start = 1'b1;
    ndone = 0; first = -1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
      if (c == 8) begin
        chk("held count", 64'(count), 64'd2);
        chk("held sum", 64'(sum_out), 64'd7);
      end
      if (c == 9) chk("held busy gap", 64'(busy), 64'd0);
      if (c == 10) begin
        chk("held restart busy", 64'(busy), 64'd1);
        start = 1'b0;
      end
      if (c == 17) chk("held second done", 64'(done), 64'd1);
    end
    chk("held first done", 64'(first), 64'd8);
    chk("held done pulses", 64'(ndone), 64'd2);
    tick();
    tick();

    // Asynchronous reset mid-COUNT.
    pr = '{chan: 2'd0, a: 32'd1, b: 32'd1, win: 24'd5, half: 1, inv: 1'b0,
           exp_cnt: 3, exp_sum: 32'd2, exp_en: 3'b001};
    run_main(pr, "prereset");
    chan_sel = 2'd0; window_len = 24'd20; ph = 0; set_ring();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("rst pre ring_en", 64'(ring_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst ring_en", 64'(ring_en), 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst count", 64'(count), 64'd0);
    chk("async rst sum", 64'(sum_out), 64'd0);
    chk("async rst a_out", 64'(a_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Narrow counter: real toggling, forced saturation, then overflow cleared on next start.
    run4(4'd15, 1, 1'b1, 8'hF0, 8'h20, 7, 1'b0, 8'h10, "c4 toggle");
    force dut4.sel_rise = 1'b1;
    run4(4'd15, 0, 1'b0, 8'd1, 8'd2, 15, 1'b1, 8'd3, "c4 saturate");
    release dut4.sel_rise;
    run4(4'd3, 0, 1'b0, 8'd5, 8'd5, 0, 1'b0, 8'd10, "c4 clear");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instrumented_adder_ctrl.md
Name: instrumented_adder_ctrl

Overview:
Parametrised measurement controller for ring-looped instrumented adders on the user project area. It selects one of NCH adder channels, loads the operands, closes that channel's ring loop, waits a settle period, then counts synchronised rising edges of the ring output over a programmable window of wb_clk_i cycles. The edge count, the captured sum and the status flags are presented to the logic analyser and wishbone side. It replaces the fixed single-adder, single-shot measurement with configurable width, channel count, window length and abort.

Parameters:
WIDTH, 32, operand/sum width of each adder channel
NCH, 2, number of adder channels (1..8)
CNT_WIDTH, 24, width of edge counter and window_len
SETTLE, 4, cycles between ring enable and counting start (>=1)
SYNC_STAGES, 2, flop stages on ring input synchroniser (>=2)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous active-high reset
start  in  1  begin a measurement (sampled in IDLE only)
abort  in  1  cancel measurement, return to IDLE
chan_sel  in  $clog2(NCH) (min 1)  channel to measure, latched on start
a_in  in  WIDTH  operand A, latched on start
b_in  in  WIDTH  operand B, latched on start
window_len  in  CNT_WIDTH  count window in clock cycles, latched on start
ring_in  in  NCH  raw ring outputs (chain_out) of each adder, asynchronous
s_in  in  WIDTH  sum output of selected adder
a_out  out  WIDTH  operand A driven to adders
b_out  out  WIDTH  operand B driven to adders
ring_en  out  NCH  one-hot ring loop enable
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on measurement completion
count  out  CNT_WIDTH  edge count of last completed measurement
sum_out  out  WIDTH  s_in captured at end of window
overflow  out  1  count saturated in last measurement

Behaviour:
- Reset (async assert, release on clock edge): state IDLE; a_out, b_out, ring_en, count, sum_out, window counter, synchroniser all 0; busy, done, overflow 0.
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE: on start=1, latch chan_sel, a_in, b_in, window_len; set ring_en = 1<<chan_sel; clear working counter and overflow; go to SETTLE. chan_sel >= NCH: ring_en = 0, measurement proceeds, count ends 0.
- SETTLE: exactly SETTLE cycles; synchroniser runs but edges are not counted; then COUNT.
- COUNT: lasts exactly window_len cycles; each cycle where synchronised ring (selected channel) goes 0->1 increments working counter. Counter saturates at all-ones and sets overflow sticky. window_len=0: COUNT is skipped (SETTLE -> DONE), count=0.
- DONE: one cycle; count <= working counter, sum_out <= s_in, done=1, ring_en <= 0; next IDLE. busy=0 in the cycle after DONE.
- Total latency start -> done = 1 + SETTLE + window_len cycles.
- start while busy: ignored. start in the same cycle as DONE: ignored; accepted from the next cycle.
- abort (any non-IDLE state): next state IDLE, ring_en <= 0, no done pulse, count/sum_out/overflow keep previous results. abort and start together in IDLE: start is ignored.
- Synchroniser: SYNC_STAGES flops per channel; edge detect on final stage versus one more delayed flop. Ring frequencies above wb_clk_i/2 undercount by design; a prescaler is out of scope.
- Reset mid-measurement: immediately ring_en = 0, all outputs return to reset values.

Decomposition:
- Package instrumented_adder_pkg holds the state enum (IDLE, SETTLE, COUNT, DONE) and the default width constants, shared with the wrapper and formal properties.
- One sub-module: ring_edge_sync (SYNC_STAGES synchroniser plus rising-edge pulse), instantiated once per channel.

Test Plan:
- Reset, then start with chan 0, a=5, b=7, window_len=10, ring toggling every 4 clocks -> done at cycle 1+SETTLE+10; count=2 or 3 per phase; sum_out=12; overflow=0.
- window_len=0 -> done 1+SETTLE cycles after start; count=0; ring_en pulsed on chan_sel then 0.
- CNT_WIDTH=4, window_len=15, ring toggling every clock -> count=7, overflow=0; repeat with window_len=15 and a faster (clock/2) stimulus forced via bypass -> count=15 saturated, overflow=1.
- abort in COUNT after 3 cycles -> IDLE next cycle, no done, ring_en=0, count holds previous value.
- start held high through a measurement and through DONE -> exactly one measurement; a second start is accepted on the cycle after DONE.
- wb_rst_i asserted asynchronously mid-COUNT -> ring_en, busy, count drop to 0 without a clock edge.
